// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D interface and its SPI engine.
package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TX1,
      GAP,
      TX2,
      DONE
   } a2d_state_t;

   localparam int unsigned GAP_CLKS     = 32;
   localparam logic [4:0]  SCLK_PRELOAD = 5'b10111;
   localparam int unsigned BITS         = 16;

   // Command word for a channel: two zero bits, channel, eleven zero bits.
   function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master (mode 3: SCLK idles high, data shifted out on falling
// edges and sampled on rising edges). One transaction per wrt pulse.
module spi_mstr16
   import a2d_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wrt,
   input  logic [15:0] cmd,
   input  logic        MISO,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI
);

   logic [4:0]  sclk_div;
   logic [4:0]  bit_cnt;
   logic [15:0] shift;

   assign SCLK    = sclk_div[4];
   assign rd_data = shift;

   // Transaction engine: divider, bit counter, shared TX/RX shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         SS_n     <= 1'b1;
         sclk_div <= SCLK_PRELOAD;
         bit_cnt  <= '0;
         shift    <= '0;
         MOSI     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (SS_n) begin
            if (wrt) begin
               SS_n     <= 1'b0;
               sclk_div <= SCLK_PRELOAD;
               bit_cnt  <= '0;
               shift    <= cmd;
            end
         end else if (bit_cnt == 5'(BITS)) begin
            // all samples taken: divider is frozen with SCLK high, release SS_n
            SS_n <= 1'b1;
            done <= 1'b1;
         end else begin
            sclk_div <= sclk_div + 5'd1;
            if (sclk_div == 5'b11111) begin
               MOSI <= shift[15];
            end
            if (sclk_div == 5'b01111) begin
               shift   <= {shift[14:0], MISO};
               bit_cnt <= bit_cnt + 5'd1;
            end
         end
      end
   end

endmodule

// File: rtl/a2d_intf.sv
// A2D interface: one conversion = command transaction, 32-clk gap, read
// transaction; the read result is presented on res with cnv_cmplt.
module a2d_intf
   import a2d_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        strt_cnv,
   input  logic [2:0]  chnnl,
   output logic        cnv_cmplt,
   output logic [11:0] res,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   a2d_state_t  state, nxt_state;
   logic [2:0]  chnnl_q;
   logic [5:0]  gap_cnt;
   logic        wrt;
   logic        accept;
   logic        spi_done;
   logic [15:0] cmd;
   logic [15:0] rd_data;

   spi_mstr16 u_spi (
      .clk     (clk),
      .rst     (rst),
      .wrt     (wrt),
      .cmd     (cmd),
      .MISO    (MISO),
      .done    (spi_done),
      .rd_data (rd_data),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   // Next-state decode and SPI launch; the accepting cycle uses the live
   // channel input since chnnl_q is only loaded on that edge.
   always_comb begin
      nxt_state = state;
      wrt       = 1'b0;
      accept    = 1'b0;
      cmd       = a2d_cmd(chnnl_q);
      case (state)
         IDLE: begin
            if (strt_cnv) begin
               accept    = 1'b1;
               wrt       = 1'b1;
               cmd       = a2d_cmd(chnnl);
               nxt_state = TX1;
            end
         end
         TX1: begin
            if (spi_done) nxt_state = GAP;
         end
         GAP: begin
            // SS_n is already high during the TX1 cycle that sees spi_done,
            // and wrt takes effect one edge after it is raised, hence -2.
            if (gap_cnt == 6'(GAP_CLKS - 2)) begin
               wrt       = 1'b1;
               nxt_state = TX2;
            end
         end
         TX2: begin
            if (spi_done) nxt_state = DONE;
         end
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // Channel capture, gap timer, completion flag and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         chnnl_q   <= '0;
         gap_cnt   <= '0;
         cnv_cmplt <= 1'b0;
         res       <= '0;
      end else begin
         if (accept) begin
            chnnl_q   <= chnnl;
            cnv_cmplt <= 1'b0;
         end
         gap_cnt <= (state == GAP) ? gap_cnt + 6'd1 : '0;
         if (state == TX2 && spi_done) begin
            cnv_cmplt <= 1'b1;
            res       <= 12'(rd_data);
         end
      end
   end

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: ADC model on the SPI pins, scoreboard of expected
// conversions, SPI timing monitor.
module tb_a2d_intf;

   logic        clk = 1'b0;
   logic        rst;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO = 1'b0;

   a2d_intf dut (
      .clk       (clk),
      .rst       (rst),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] cmd;
      logic [11:0] res;
      int unsigned due;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_vec = 0;
   int unsigned n_mis = 0;
   int unsigned done_seen = 0;
   logic [11:0] adc_val = '0;

   // ADC model and SPI monitor state (written only by the negedge block)
   logic        prev_ss = 1'b1;
   logic        prev_sclk = 1'b1;
   logic        prev_cmplt = 1'b0;
   logic        is_read = 1'b0;
   logic        aborted = 1'b0;
   logic [15:0] resp = '0;
   logic [15:0] mosi_cap = '0;
   logic [15:0] cmd1 = '0;
   logic [15:0] cmd2 = '0;
   int unsigned fall_cyc = 0;
   int unsigned last_rise = 0;
   int unsigned rises = 0;
   int          first_fall = -1;
   int unsigned per_err = 0;
   int unsigned ss_len = 0;
   int unsigned rises_l = 0;
   int          ff_l = -1;
   int unsigned per_err_l = 0;
   int unsigned high_err = 0;
   int unsigned done_cnt = 0;

   // ADC slave model plus timing statistics of each completed transaction
   always @(negedge clk) begin
      if (rst) begin
         is_read = 1'b0;
         if (SS_n === 1'b0) aborted = 1'b1;
      end
      if (prev_ss && SS_n === 1'b0) begin
         fall_cyc   = cyc;
         rises      = 0;
         first_fall = -1;
         per_err    = 0;
         mosi_cap   = '0;
         resp       = is_read ? {4'($urandom), adc_val} : 16'($urandom);
      end
      if (SS_n === 1'b0) begin
         if (prev_sclk && !SCLK) begin
            if (first_fall < 0) first_fall = int'(cyc - fall_cyc);
            MISO = resp[15];
            resp = {resp[14:0], 1'b0};
         end
         if (!prev_sclk && SCLK) begin
            if (rises > 0 && cyc - last_rise != 32) per_err++;
            last_rise = cyc;
            rises++;
            mosi_cap = {mosi_cap[14:0], MOSI};
         end
      end else if (SCLK === 1'b0) begin
         high_err++;
      end
      if (!prev_ss && SS_n === 1'b1) begin
         if (aborted) begin
            aborted = 1'b0;
         end else begin
            ss_len    = cyc - fall_cyc;
            rises_l   = rises;
            ff_l      = first_fall;
            per_err_l = per_err;
            if (is_read) cmd2 = mosi_cap;
            else         cmd1 = mosi_cap;
            is_read = ~is_read;
         end
      end
      if (cnv_cmplt === 1'b1 && !prev_cmplt) done_cnt++;
      prev_ss    = (SS_n !== 1'b0);
      prev_sclk  = (SCLK !== 1'b0);
      prev_cmplt = (cnv_cmplt === 1'b1);
   end

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse strt_cnv for one clk; push an expectation when it should be accepted.
   task automatic start_conv(input logic [2:0] ch, input logic [11:0] val, input bit expect_acc);
      exp_t e;
      @(posedge clk); #1;
      if (expect_acc) begin
         adc_val = val;
         e.cmd   = {2'b00, ch, 11'h000};
         e.res   = val;
         e.due   = cyc + 1046;
         sb_q.push_back(e);
      end
      strt_cnv = 1'b1;
      chnnl    = ch;
      @(posedge clk); #1;
      strt_cnv = 1'b0;
      chnnl    = ~ch;
   endtask

   // Wait (bounded) for the next cnv_cmplt rise, pop and compare.
   task automatic wait_result();
      exp_t e;
      bit   got = 1'b0;
      for (int i = 0; i < 1300 && !got; i++) begin
         @(negedge clk); #1;
         if (done_cnt != done_seen) got = 1'b1;
      end
      if (!got) begin
         chk_val("done_timeout", done_cnt, done_seen + 1);
         return;
      end
      done_seen = done_cnt;
      chk_val("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      chk_val("latency",    cyc, e.due);
      chk_val("res",        32'(res), 32'(e.res));
      chk_val("cmplt_high", 32'(cnv_cmplt), 32'd1);
      chk_val("cmd_tx1",    32'(cmd1), 32'(e.cmd));
      chk_val("cmd_tx2",    32'(cmd2), 32'(e.cmd));
      chk_val("ss_low_len", ss_len, 32'd506);
      chk_val("sclk_rises", rises_l, 32'd16);
      chk_val("first_fall", 32'(ff_l), 32'd9);
      chk_val("sclk_period_err", per_err_l, 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      strt_cnv = 1'b0;
      chnnl    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_val("rst_ss_n",  32'(SS_n),      32'd1);
      chk_val("rst_sclk",  32'(SCLK),      32'd1);
      chk_val("rst_mosi",  32'(MOSI),      32'd0);
      chk_val("rst_cmplt", 32'(cnv_cmplt), 32'd0);
      chk_val("rst_res",   32'(res),       32'd0);
      rst = 1'b0;

      // basic conversion on channel 5
      start_conv(3'd5, 12'hA5C, 1'b1);
      wait_result();
      chk_val("cmd_ch5", 32'(cmd1), 32'h2800);

      // second request while busy is ignored
      start_conv(3'd7, 12'h3C1, 1'b1);
      repeat (98) @(posedge clk);
      start_conv(3'd2, 12'h000, 1'b0);
      wait_result();
      chk_val("cmd_ch7", 32'(cmd2), 32'h3800);
      repeat (1200) @(negedge clk);
      #1;
      chk_val("single_done", done_cnt, done_seen);

      // cnv_cmplt clears on accept, res holds until the new result
      start_conv(3'd4, 12'h7E2, 1'b1);
      chk_val("clr_cmplt",  32'(cnv_cmplt), 32'd0);
      chk_val("clr_res_old", 32'(res),      32'h3C1);
      repeat (1044) @(posedge clk);
      #1;
      chk_val("late_cmplt",  32'(cnv_cmplt), 32'd0);
      chk_val("late_res_old", 32'(res),      32'h3C1);
      wait_result();

      // reset 200 clks into the read transaction
      start_conv(3'd6, 12'hFFF, 1'b0);
      repeat (737) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk_val("abort_ss_n",  32'(SS_n),      32'd1);
      chk_val("abort_sclk",  32'(SCLK),      32'd1);
      chk_val("abort_cmplt", 32'(cnv_cmplt), 32'd0);
      chk_val("abort_res",   32'(res),       32'd0);
      repeat (1100) @(negedge clk);
      #1;
      chk_val("abort_no_done", done_cnt, done_seen);
      chk_val("abort_res_hold", 32'(res), 32'd0);
      start_conv(3'd1, 12'h5A5, 1'b1);
      wait_result();

      // channel sweep
      for (int ch = 0; ch < 8; ch++) begin
         start_conv(3'(ch), {3'(ch), 9'h1FF}, 1'b1);
         wait_result();
      end

      chk_val("sclk_high_idle", high_err, 32'd0);
      chk_val("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port strt_cnv, input, 1 bit: single-cycle conversion request from the motion controller.
REQ-004 The block SHALL have port chnnl, input, 3 bits: A2D channel, sampled when strt_cnv is accepted.
REQ-005 The block SHALL have port cnv_cmplt, output, 1 bit: conversion done; res is valid while it is high.
REQ-006 The block SHALL have port res, output, 12 bits: conversion result.
REQ-007 The block SHALL have port SS_n, output, 1 bit: ADC slave select, active-low.
REQ-008 The block SHALL have port SCLK, output, 1 bit: SPI clock, idle high.
REQ-009 The block SHALL have port MOSI, output, 1 bit: command data to the ADC.
REQ-010 The block SHALL have port MISO, input, 1 bit: result data from the ADC.

Function
REQ-011 Each conversion SHALL consist of two 16-bit SPI transactions: a command transaction, then a read transaction.
REQ-012 Command word: SHALL be {2'b00, chnnl, 11'h000}, MSB first. Read-transaction MOSI word: same value.
REQ-013 The state machine SHALL have states IDLE, TX1, GAP, TX2, DONE.
REQ-014 Transition IDLE→TX1: on strt_cnv.
REQ-015 Transition TX1→GAP: at end of the transaction.
REQ-016 Transition GAP→TX2: after 32 clk cycles with SS_n high.
REQ-017 Transition TX2→DONE: at end of the transaction. DONE→IDLE occurs next clk.
REQ-018 strt_cnv in any state other than IDLE SHALL be ignored; chnnl is captured only on acceptance.
REQ-019 Clock divider: 5-bit sclk_div. SCLK = sclk_div[4]. Preloaded to 5'b10111 on transaction start, incremented every clk while a transaction is active.
REQ-020 Falling SCLK edge (sclk_div 11111→00000): MOSI SHALL present the next bit; the first falling edge occurs 9 clks after SS_n falls.
REQ-021 Rising SCLK edge (sclk_div 01111→10000): MISO SHALL be sampled into the shift register LSB, and the shift register SHALL shift left.
REQ-022 A 5-bit bit counter SHALL count samples. After the 16th sample, SCLK SHALL be held high and SS_n SHALL rise on the next clk, so SS_n is low for exactly 506 clks per transaction.
REQ-023 On TX2→DONE, res SHALL be loaded with shift[11:0] of the read transaction; MISO data from the command transaction is discarded.
REQ-024 cnv_cmplt SHALL be set on entry to DONE and held until the next accepted strt_cnv, which clears it on that same clock edge.
REQ-025 res SHALL hold its value until the next DONE.
REQ-026 SCLK and MOSI SHALL be driven from flops, glitch-free; MOSI is don't-care while SS_n is high.
REQ-027 Total latency from strt_cnv to cnv_cmplt high SHALL be 506+32+506+1 = 1045 clks (tolerance 0).

Reset
REQ-028 On rst: state=IDLE, SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=12'h000, counters cleared.
REQ-029 rst mid-transaction SHALL abort immediately with SS_n high, and SHALL NOT produce a cnv_cmplt; res keeps its reset value.
REQ-030 rst SHALL take priority over strt_cnv in the same cycle.

Structure
REQ-031 The state enum and the constants GAP_CLKS=32, SCLK_PRELOAD=5'b10111 and BITS=16 SHALL reside in shared package a2d_pkg.
REQ-032 The SPI engine SHALL be sub-module spi_mstr16: inputs clk, rst, wrt, cmd[15:0], MISO; outputs done, rd_data[15:0], SS_n, SCLK, MOSI.
REQ-033 a2d_intf SHALL sequence spi_mstr16 twice per conversion.

Verification
REQ-034 Basic conversion: strt_cnv with chnnl=3'd5 and an ADC model returning 12'hA5C → MOSI command 16'h2800, cnv_cmplt high 1045 clks later, res=12'hA5C.
REQ-035 SPI timing: observe one transaction → SS_n low 506 clks, 16 rising SCLK edges, SCLK period 32 clks, first SCLK fall 9 clks after SS_n fall, SCLK high whenever SS_n is high.
REQ-036 Busy ignore: second strt_cnv (chnnl=3'd2) issued 100 clks after the first (chnnl=3'd7) → only one conversion, command 16'h3800, single DONE.
REQ-037 cnv_cmplt clear: after DONE, strt_cnv → cnv_cmplt low the following clk and stays low for 1045 clks; res holds the old value until new DONE.
REQ-038 Reset mid-TX2: assert rst 200 clks into TX2 → next clk SS_n=1, SCLK=1, cnv_cmplt=0, res=0; a new strt_cnv then completes normally.
REQ-039 All channels: sweep chnnl 0..7 with the model returning {chnnl,9'h1FF} → res matches each, MOSI[13:11]=chnnl.
